// File: rtl/nic_buffered.sv
// Buffered NIC between a processing element and its mesh router port.
// DEPTH-entry FIFOs each way, occupancy status words, sticky overflow/underflow flags.
module nic_buffered #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int VC_BIT     = DATA_WIDTH - 1,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        SEL_IN_DATA  = 2'b00,
        SEL_IN_STAT  = 2'b01,
        SEL_OUT_DATA = 2'b10,
        SEL_OUT_STAT = 2'b11
    } sel_e;

    logic [DATA_WIDTH-1:0] r_in_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] r_out_mem [DEPTH];
    logic [PW-1:0]         r_in_wptr, r_in_rptr, r_out_wptr, r_out_rptr;
    logic [CNT_WIDTH-1:0]  r_in_count, r_out_count;
    logic                  r_in_underflow, r_out_overflow;
    logic                  r_net_so;
    logic [DATA_WIDTH-1:0] r_net_do;

    sel_e                  w_sel;
    logic                  w_rd, w_wr;
    logic                  w_in_empty, w_out_empty, w_out_full;
    logic                  w_in_push, w_in_pop, w_uf_set;
    logic                  w_out_push, w_out_pop, w_of_set, w_flag_clr;
    logic [DATA_WIDTH-1:0] w_in_head, w_out_head;

    function automatic logic [DATA_WIDTH-1:0] pack_status(
        input logic                 flag,
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 b0
    );
        logic [DATA_WIDTH-1:0] s;
        s                = '0;
        s[0]             = b0;
        s[CNT_WIDTH:1]   = cnt;
        s[CNT_WIDTH+1]   = flag;
        return s;
    endfunction

    assign w_sel       = sel_e'(addr);
    assign w_rd        = nicEn & ~nicWrEn;
    assign w_wr        = nicEn & nicWrEn;
    assign w_in_empty  = (r_in_count == '0);
    assign w_out_empty = (r_out_count == '0);
    assign w_out_full  = (r_out_count == FULL_CNT);
    assign w_in_head   = r_in_mem[r_in_rptr];
    assign w_out_head  = r_out_mem[r_out_rptr];

    assign net_ri      = (r_in_count != FULL_CNT);
    assign net_so      = r_net_so;
    assign net_do      = r_net_do;

    assign w_in_push   = net_si & net_ri;
    assign w_in_pop    = w_rd & (w_sel == SEL_IN_DATA) & ~w_in_empty;
    assign w_uf_set    = w_rd & (w_sel == SEL_IN_DATA) & w_in_empty;
    assign w_out_push  = w_wr & (w_sel == SEL_OUT_DATA) & ~w_out_full;
    assign w_of_set    = w_wr & (w_sel == SEL_OUT_DATA) & w_out_full;
    assign w_flag_clr  = w_wr & (w_sel == SEL_OUT_STAT);
    // Inject only when the head's VC tag is opposite the current mesh polarity.
    assign w_out_pop   = ~w_out_empty & net_ro & (w_out_head[VC_BIT] != net_polarity);

    always_comb begin
        d_out = '0;
        case (w_sel)
            SEL_IN_DATA:  d_out = w_in_empty ? '0 : w_in_head;
            SEL_IN_STAT:  d_out = pack_status(r_in_underflow, r_in_count, ~w_in_empty);
            SEL_OUT_STAT: d_out = pack_status(r_out_overflow, r_out_count, w_out_full);
            default:      d_out = '0;
        endcase
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (w_in_push)  r_in_mem[r_in_wptr]   <= net_di;
        if (w_out_push) r_out_mem[r_out_wptr] <= d_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_wptr  <= '0;
            r_in_rptr  <= '0;
            r_in_count <= '0;
        end else begin
            if (w_in_push) r_in_wptr <= r_in_wptr + 1'b1;
            if (w_in_pop)  r_in_rptr <= r_in_rptr + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_count <= r_in_count + 1'b1;
                2'b01:   r_in_count <= r_in_count - 1'b1;
                default: r_in_count <= r_in_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_wptr  <= '0;
            r_out_rptr  <= '0;
            r_out_count <= '0;
            r_net_so    <= 1'b0;
            r_net_do    <= '0;
        end else begin
            if (w_out_push) r_out_wptr <= r_out_wptr + 1'b1;
            if (w_out_pop) begin
                r_out_rptr <= r_out_rptr + 1'b1;
                r_net_do   <= w_out_head;
            end
            r_net_so <= w_out_pop;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_count <= r_out_count + 1'b1;
                2'b01:   r_out_count <= r_out_count - 1'b1;
                default: r_out_count <= r_out_count;
            endcase
        end
    end

    // A status-register write wins over a same-cycle error event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_underflow <= 1'b0;
            r_out_overflow <= 1'b0;
        end else if (w_flag_clr) begin
            r_in_underflow <= 1'b0;
            r_out_overflow <= 1'b0;
        end else begin
            if (w_uf_set) r_in_underflow <= 1'b1;
            if (w_of_set) r_out_overflow <= 1'b1;
        end
    end

endmodule
